// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the single memory port between the stack engine, the CPU
// fetch/execute path and the DMA/video fetch unit. One transaction at a
// time: IDLE arbitrates and latches the winner's request, ACCESS holds the
// strobes until mem_ready, and ACK pulses the winner's ack for one cycle.
// Priority is stack > CPU > DMA, except that after STARVE_LIMIT consecutive
// CPU grants with DMA waiting, DMA is promoted above CPU (never above stack).
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an ACCESS that has
// not seen mem_ready after TIMEOUT_CYCLES cycles (read data 8'hFF, sticky
// timeout_err). Without it, ACCESS waits indefinitely and timeout_err is 0.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   {stk,cpu,dma}_req/we/addr/wdata requester side, req held until ack
//   {stk,cpu,dma}_ack              one-cycle completion pulse
//   {stk,cpu,dma}_rdata            last read data per requester (held)
//   mem_addr/mem_wdata             latched address / write data
//   mem_read/mem_write             access strobes, high throughout ACCESS
//   mem_rdata/mem_ready            memory read data / access complete
//   grant                          owner: 00 none, 01 stk, 10 cpu, 11 dma
//   busy                           high in ACCESS or ACK
//   timeout_err                    sticky timeout flag
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stk_req,
    input  logic        cpu_req,
    input  logic        dma_req,
    input  logic        stk_we,
    input  logic        cpu_we,
    input  logic        dma_we,
    input  logic [15:0] stk_addr,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  stk_wdata,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  dma_wdata,
    output logic        stk_ack,
    output logic        cpu_ack,
    output logic        dma_ack,
    output logic [7:0]  stk_rdata,
    output logic [7:0]  cpu_rdata,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_t;
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_STK  = 2'b01,
        OWN_CPU  = 2'b10,
        OWN_DMA  = 2'b11
    } owner_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d, winner;
    logic [SW-1:0] streak_q, streak_d;
    logic          we_q, we_d;
    logic          sel_we;
    logic [15:0]   sel_addr, addr_d;
    logic [7:0]    sel_wdata, wdata_d;
    logic          read_d, write_d, busy_d;
    logic          stk_ack_d, cpu_ack_d, dma_ack_d;
    logic [7:0]    stk_rdata_d, cpu_rdata_d, dma_rdata_d;
    logic          tmo_hit, done;
    logic [7:0]    cap_data;

    assign grant = owner_q;

    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        winner = OWN_NONE;
        if (stk_req)                                winner = OWN_STK;
        else if (dma_req && streak_q == STREAK_MAX) winner = OWN_DMA;
        else if (cpu_req)                           winner = OWN_CPU;
        else if (dma_req)                           winner = OWN_DMA;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 16'h0000;
        sel_wdata = 8'h00;
        case (winner)
            OWN_STK: begin sel_we = stk_we; sel_addr = stk_addr; sel_wdata = stk_wdata; end
            OWN_CPU: begin sel_we = cpu_we; sel_addr = cpu_addr; sel_wdata = cpu_wdata; end
            OWN_DMA: begin sel_we = dma_we; sel_addr = dma_addr; sel_wdata = dma_wdata; end
            default: ;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt_q;
    logic          terr_q;

    // tcnt_q counts completed ACCESS cycles; the last allowed one aborts.
    assign tmo_hit     = (state_q == ST_ACCESS) && !mem_ready && (tcnt_q == TMO_LAST);
    assign timeout_err = terr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            if (state_q == ST_ACCESS && !done) tcnt_q <= tcnt_q + TW'(1);
            else                               tcnt_q <= '0;
            if (tmo_hit) terr_q <= 1'b1;
        end
    end
`else
    // The timeout length has no effect in this build; fold it into a net
    // that is intentionally left unused.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign done     = (state_q == ST_ACCESS) && (mem_ready || tmo_hit);
    // An aborted read returns all-ones so the requester sees a poisoned byte.
    assign cap_data = mem_ready ? mem_rdata : 8'hFF;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        we_d        = we_q;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        read_d      = mem_read;
        write_d     = mem_write;
        busy_d      = busy;
        stk_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        stk_rdata_d = stk_rdata;
        cpu_rdata_d = cpu_rdata;
        dma_rdata_d = dma_rdata;

        case (state_q)
            ST_IDLE: begin
                if (winner != OWN_NONE) begin
                    state_d = ST_ACCESS;
                    owner_d = winner;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    read_d  = !sel_we;
                    write_d = sel_we;
                    busy_d  = 1'b1;
                    // Streak measures how long DMA has waited behind CPU;
                    // stack grants leave it untouched.
                    if (!dma_req || winner == OWN_DMA)
                        streak_d = '0;
                    else if (winner == OWN_CPU && streak_q != STREAK_MAX)
                        streak_d = streak_q + SW'(1);
                end
            end
            ST_ACCESS: begin
                if (done) begin
                    state_d = ST_ACK;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    case (owner_q)
                        OWN_STK: begin stk_ack_d = 1'b1; if (!we_q) stk_rdata_d = cap_data; end
                        OWN_CPU: begin cpu_ack_d = 1'b1; if (!we_q) cpu_rdata_d = cap_data; end
                        OWN_DMA: begin dma_ack_d = 1'b1; if (!we_q) dma_rdata_d = cap_data; end
                        default: ;
                    endcase
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            streak_q  <= '0;
            we_q      <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            stk_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            // NOTE: the rdata holding registers are visible outputs with a
            // defined reset value, so they are reset like any control flop.
            stk_rdata <= 8'h00;
            cpu_rdata <= 8'h00;
            dma_rdata <= 8'h00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            we_q      <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_read  <= read_d;
            mem_write <= write_d;
            busy      <= busy_d;
            stk_ack   <= stk_ack_d;
            cpu_ack   <= cpu_ack_d;
            dma_ack   <= dma_ack_d;
            stk_rdata <= stk_rdata_d;
            cpu_rdata <= cpu_rdata_d;
            dma_rdata <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Transaction-level reference model of the arbiter plus a compare process
// that checks every DUT output on every falling edge. Directed scenarios
// pin the model with literal expectations; a randomized phase follows.
module tb_mem_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 16;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stk_req, cpu_req, dma_req;
    logic        stk_we, cpu_we, dma_we;
    logic [15:0] stk_addr, cpu_addr, dma_addr;
    logic [7:0]  stk_wdata, cpu_wdata, dma_wdata;
    logic        stk_ack, cpu_ack, dma_ack;
    logic [7:0]  stk_rdata, cpu_rdata, dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .stk_req(stk_req), .cpu_req(cpu_req), .dma_req(dma_req),
        .stk_we(stk_we), .cpu_we(cpu_we), .dma_we(dma_we),
        .stk_addr(stk_addr), .cpu_addr(cpu_addr), .dma_addr(dma_addr),
        .stk_wdata(stk_wdata), .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
        .stk_ack(stk_ack), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
        .stk_rdata(stk_rdata), .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 waiting for a request, 1 memory access, 2 acknowledge.
    int m_phase, m_owner, m_we, m_addr, m_wdata, m_wait, m_streak, m_terr, m_win;
    int m_rdata[4];

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0;
            m_wait = 0; m_streak = 0; m_terr = 0;
            for (int i = 0; i < 4; i++) m_rdata[i] = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_win = 0;
                    if (stk_req)                             m_win = 1;
                    else if (dma_req && m_streak >= STARVE)  m_win = 3;
                    else if (cpu_req)                        m_win = 2;
                    else if (dma_req)                        m_win = 3;
                    if (m_win != 0) begin
                        if (!dma_req || m_win == 3)            m_streak = 0;
                        else if (m_win == 2 && m_streak < STARVE) m_streak = m_streak + 1;
                        m_owner = m_win;
                        m_phase = 1;
                        m_wait  = 0;
                        case (m_win)
                            1: begin m_we = stk_we; m_addr = stk_addr; m_wdata = stk_wdata; end
                            2: begin m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; end
                            default: begin m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata; end
                        endcase
                    end
                end
                1: begin
                    m_wait = m_wait + 1;
                    if (mem_ready || (TMO_EN && m_wait >= TMO)) begin
                        m_phase = 2;
                        if (m_we == 0) m_rdata[m_owner] = mem_ready ? int'(mem_rdata) : 'hFF;
                        if (!mem_ready) m_terr = 1;
                    end
                end
                default: begin
                    m_phase = 0;
                    m_owner = 0;
                end
            endcase
        end
    end

    function automatic logic exp_ack(input int who);
        return (m_phase == 2) && (m_owner == who);
    endfunction

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            check("grant",       grant,       m_owner);
            check("busy",        busy,        m_phase != 0);
            check("mem_read",    mem_read,    (m_phase == 1) && (m_we == 0));
            check("mem_write",   mem_write,   (m_phase == 1) && (m_we != 0));
            check("mem_addr",    mem_addr,    m_addr);
            check("mem_wdata",   mem_wdata,   m_wdata);
            check("stk_ack",     stk_ack,     exp_ack(1));
            check("cpu_ack",     cpu_ack,     exp_ack(2));
            check("dma_ack",     dma_ack,     exp_ack(3));
            check("stk_rdata",   stk_rdata,   m_rdata[1]);
            check("cpu_rdata",   cpu_rdata,   m_rdata[2]);
            check("dma_rdata",   dma_rdata,   m_rdata[3]);
            check("timeout_err", timeout_err, m_terr);
        end
    end

    // ---------------- stimulus ----------------
    int exp_seq[10] = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};

    initial begin
        int stk_t, cpu_t, strobes, acks;
        int seq[$];
        bit got;

        rst = 1'b1;
        stk_req = 0; cpu_req = 0; dma_req = 0;
        stk_we = 0; cpu_we = 0; dma_we = 0;
        stk_addr = 0; cpu_addr = 0; dma_addr = 0;
        stk_wdata = 0; cpu_wdata = 0; dma_wdata = 0;
        mem_rdata = 0; mem_ready = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_on = 1'b1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_rdata", {stk_rdata, cpu_rdata, dma_rdata}, 0);

        // Single CPU read
        rst = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8000;
        mem_ready = 1; mem_rdata = 8'hA9;
        @(negedge clk);
        check("t1_read", mem_read, 1);
        check("t1_grant", grant, 2'b10);
        check("t1_addr", mem_addr, 16'h8000);
        check("t1_ack_early", cpu_ack, 0);
        @(negedge clk);
        check("t1_ack", cpu_ack, 1);
        check("t1_read_off", mem_read, 0);
        check("t1_rdata", cpu_rdata, 8'hA9);
        cpu_req = 0;
        @(negedge clk);
        check("t1_idle_grant", grant, 0);
        check("t1_ack_once", cpu_ack, 0);

        // Stack write racing a CPU read
        stk_req = 1; stk_we = 1; stk_addr = 16'h01FD; stk_wdata = 8'h42;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; mem_rdata = 8'h5A;
        stk_t = -1; cpu_t = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("t2_grant_stk", grant, 2'b01);
                check("t2_write", mem_write, 1);
                check("t2_addr", mem_addr, 16'h01FD);
                check("t2_wdata", mem_wdata, 8'h42);
            end
            if (stk_ack && stk_t < 0) begin stk_t = cyc; stk_req = 0; end
            if (cpu_ack && cpu_t < 0) begin cpu_t = cyc; cpu_req = 0; end
            if (stk_t >= 0 && cpu_t >= 0) break;
        end
        stk_req = 0; cpu_req = 0;
        check("t2_stk_ack_cycle", stk_t, 2);
        check("t2_ack_gap", cpu_t - stk_t, 3);
        check("t2_cpu_rdata", cpu_rdata, 8'h5A);
        check("t2_stk_rdata_kept", stk_rdata, 8'h00);

        // Starvation guard: CPU and DMA both held high
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2000;
        dma_req = 1; dma_we = 0; dma_addr = 16'hA000;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (cpu_ack) seq.push_back(2);
            if (dma_ack) seq.push_back(3);
            if (seq.size() >= 10) break;
        end
        cpu_req = 0; dma_req = 0;
        check("t3_count", seq.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t3_grant%0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);

        // Wait states: mem_ready low for 5 ACCESS cycles
        @(negedge clk);
        dma_req = 1; dma_we = 0; dma_addr = 16'hC000; mem_ready = 0; mem_rdata = 8'h3C;
        strobes = 0; acks = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (mem_read) begin
                strobes++;
                check("t4_addr_stable", mem_addr, 16'hC000);
            end
            if (dma_ack) begin acks++; dma_req = 0; end
            if (strobes == 6) mem_ready = 1;
        end
        dma_req = 0;
        check("t4_strobes", strobes, 6);
        check("t4_acks", acks, 1);
        check("t4_rdata", dma_rdata, 8'h3C);

        // Reset in the second ACCESS cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4444; mem_ready = 0;
        @(negedge clk);
        check("t5_access", mem_read, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("t5_strobe_off", mem_read, 0);
        check("t5_grant", grant, 0);
        check("t5_no_ack", cpu_ack, 0);
        check("t5_cpu_rdata", cpu_rdata, 8'h00);
        check("t5_dma_rdata", dma_rdata, 8'h00);
        rst = 0; cpu_req = 0; mem_ready = 1;
        repeat (3) @(negedge clk);
        check("t5_quiet", {cpu_ack, busy}, 0);

        // Memory stuck not-ready on a DMA read
        dma_req = 1; dma_we = 0; dma_addr = 16'hD000; mem_ready = 0;
        strobes = 0; got = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (mem_read) strobes++;
            if (dma_ack) begin got = 1; dma_req = 0; break; end
        end
        dma_req = 0;
        check("t6_got_ack", got, 1);
        check("t6_strobes", strobes, TMO);
        check("t6_rdata", dma_rdata, 8'hFF);
        check("t6_err", timeout_err, 1);
        repeat (5) @(negedge clk);
        check("t6_err_sticky", timeout_err, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t6_err_cleared", timeout_err, 0);
`else
        repeat (40) begin
            @(negedge clk);
            if (mem_read) strobes++;
            if (dma_ack) got = 1;
        end
        check("t6_wait_strobes", strobes, 40);
        check("t6_no_ack", got, 0);
        mem_ready = 1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (dma_ack) begin got = 1; dma_req = 0; break; end
        end
        dma_req = 0;
        check("t6_late_ack", got, 1);
        check("t6_err_tied", timeout_err, 0);
`endif
        mem_ready = 1;
        @(negedge clk);

        // Randomized traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 499) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = 8'($urandom);
            if (stk_req && exp_ack(1)) stk_req = 1'($urandom_range(0, 1));
            else if (!stk_req)         stk_req = ($urandom_range(0, 3) == 0);
            if (cpu_req && exp_ack(2)) cpu_req = 1'($urandom_range(0, 1));
            else if (!cpu_req)         cpu_req = ($urandom_range(0, 1) == 0);
            if (dma_req && exp_ack(3)) dma_req = 1'($urandom_range(0, 1));
            else if (!dma_req)         dma_req = ($urandom_range(0, 2) == 0);
            stk_we = 1'($urandom); stk_addr = 16'($urandom); stk_wdata = 8'($urandom);
            cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
        end
        rst = 0; stk_req = 0; cpu_req = 0; dma_req = 0; mem_ready = 1;
        repeat (10) @(negedge clk);
        cmp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter that shares the single 6502 memory port between three requesters: stack engine, CPU fetch/execute, and a DMA/video fetch unit. It grants one transaction at a time under fixed priority (stack > CPU > DMA) with a starvation guard for DMA. It drives the memory-interface strobes and holds them until the memory signals ready. It then returns read data and a one-cycle acknowledge to the winning requester. It sits between the CPU core/stack pointer logic and `memory_interface`, replacing ad-hoc combinational muxing.

## Interface
- `STARVE_LIMIT`, 4: consecutive CPU grants while DMA is waiting before DMA is promoted above CPU.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles before abort. Used only with `MEM_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stk_req`, `cpu_req`, `dma_req`  in  1 each  transaction request; level, held until the corresponding ack.
- `stk_we`, `cpu_we`, `dma_we`  in  1 each  1 = write, 0 = read.
- `stk_addr`, `cpu_addr`, `dma_addr`  in  16 each  byte address.
- `stk_wdata`, `cpu_wdata`, `dma_wdata`  in  8 each  write data.
- `stk_ack`, `cpu_ack`, `dma_ack`  out  1 each  one-cycle completion pulse.
- `stk_rdata`, `cpu_rdata`, `dma_rdata`  out  8 each  last read data for that requester; held.
- `mem_addr`  out  16  address to memory interface.
- `mem_wdata`  out  8  write data to memory interface.
- `mem_read`, `mem_write`  out  1 each  access strobes; mutually exclusive.
- `mem_rdata`  in  8  read data from memory interface.
- `mem_ready`  in  1  access complete; sampled only in ACCESS.
- `grant`  out  2  current owner: 00 none, 01 stack, 10 CPU, 11 DMA.
- `busy`  out  1  high in ACCESS or ACK.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- FSM states are IDLE, ACCESS and ACK.
- IDLE:
  - If any req is high, arbitrate, then register the winner's addr/wdata/we and `grant`, and go to ACCESS.
  - If no req is high, stay in IDLE with `grant`=00.
- Arbitration order is stack > CPU > DMA.
  - Exception: when `streak == STARVE_LIMIT` and `dma_req` is high, DMA beats CPU. Stack is never preempted.
- `streak` counter, width `$clog2(STARVE_LIMIT+1)`:
  - Increments on each CPU grant while `dma_req` is high, saturating at `STARVE_LIMIT`.
  - Clears on a DMA grant, or at any arbitration where `dma_req` is low.
- ACCESS:
  - `mem_read` = !we and `mem_write` = we, both asserted continuously.
  - `mem_addr`/`mem_wdata` come from the latched values. Requester inputs are ignored during ACCESS and ACK.
  - On sampling `mem_ready`=1, capture `mem_rdata` into the owner's rdata register (reads only) and go to ACK.
- ACK:
  - Strobes low; the owner's ack is high for exactly this cycle.
  - Next state is IDLE.
- A req still high in the IDLE cycle after ACK counts as a new transaction; back-to-back accesses are allowed.
- rdata registers are unchanged by writes and by other requesters' transactions.

## Timing
- All outputs are registered.
- Reset values: strobes 0, acks 0, all rdata 8'h00, `mem_addr` 16'h0000, `mem_wdata` 8'h00, `grant` 00, `busy` 0, `timeout_err` 0, `streak` 0, state IDLE.
- Minimum latency, counted from the edge that samples req high:
  - ACCESS in cycle 1.
  - With `mem_ready` already high, ACK in cycle 2.
  - IDLE in cycle 3.
- Throughput is 1 transaction per 3 cycles, plus memory wait states.
- Simultaneous requests resolve in a single cycle. Losers keep req high and are served in later IDLE cycles.
- `rst` asserted in any state aborts the transaction: no ack is issued, and all registers go to their reset values on that edge.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter runs while in ACCESS.
  - If `mem_ready` is still 0 after `TIMEOUT_CYCLES` ACCESS cycles, go to ACK anyway.
  - On a read abort, the owner's rdata = 8'hFF.
  - `timeout_err` is set and stays set until `rst`.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - ACCESS waits indefinitely for `mem_ready`.
  - `timeout_err` is tied 0.

## Test plan
- Single CPU read: `cpu_addr`=16'h8000, `mem_ready` high, `mem_rdata`=8'hA9 -> `mem_read` high for 1 cycle, `cpu_ack` pulse in cycle 2, `cpu_rdata`=8'hA9, `grant`=10 during ACCESS.
- Simultaneous stack write (addr 16'h01FD, data 8'h42) and CPU read -> stack served first (`mem_write`, `grant`=01), then CPU; `stk_ack` precedes `cpu_ack` by 3 cycles.
- Starvation guard: `cpu_req` and `dma_req` held high continuously, `STARVE_LIMIT`=4 -> grant sequence CPU×4, DMA, CPU×4, DMA.
- Wait states: `mem_ready` low for 5 ACCESS cycles -> strobe held 6 cycles, single ack, address stable throughout.
- Reset mid-ACCESS: `rst` pulsed in the second ACCESS cycle -> strobes 0 next cycle, no ack, `grant`=00, rdata 8'h00.
- Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): `mem_ready` stuck 0 on a DMA read -> `dma_ack` after 16 ACCESS cycles, `dma_rdata`=8'hFF, `timeout_err`=1 until `rst`.
